sa_seq_ctrl: RTL

//  Sequencer for an N x N output-stationary systolic grid of 4-bit signed MAC cells.

---
 rtl/sa_seq_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sa_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic MAC grid:
// clear, skewed feed window with edge-feeder masks, then result hold.
module sa_seq_ctrl #(
  parameter int N  = 4,
  parameter int KW = 8,
  parameter int CW = KW + 4
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          abort,
  input  logic          res_ack,
  output logic          busy,
  output logic          mac_en,
  output logic          mac_upd,
  output logic          mac_clr,
  output logic [CW-1:0] feed_cnt,
  output logic [N-1:0]  row_vld,
  output logic [N-1:0]  col_vld,
  output logic          res_valid,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FEED,
    DONE
  } state_t;

  state_t        state;
  logic [KW-1:0] k_reg;
  logic [CW-1:0] t_last;
  logic [CW-1:0] t_nxt;
  logic [N-1:0]  vld_nxt;

  assign t_last = CW'(k_reg) + CW'(2 * N - 3);
  assign t_nxt  = (state == FEED) ? feed_cnt + CW'(1) : '0;

  // masks are registered, so they are computed for the upcoming t
  always_comb begin
    vld_nxt = '0;
    for (int i = 0; i < N; i++) begin
      vld_nxt[i] = (t_nxt >= CW'(i)) &&
                   ((t_nxt - CW'(i)) < CW'(k_reg));
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      k_reg     <= '0;
      busy      <= 1'b0;
      mac_en    <= 1'b0;
      mac_upd   <= 1'b0;
      mac_clr   <= 1'b0;
      feed_cnt  <= '0;
      row_vld   <= '0;
      col_vld   <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state != IDLE && abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        mac_en    <= 1'b0;
        mac_upd   <= 1'b0;
        mac_clr   <= 1'b0;
        feed_cnt  <= '0;
        row_vld   <= '0;
        col_vld   <= '0;
        res_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              if (k_len != '0) begin
                state   <= CLEAR;
                k_reg   <= k_len;
                busy    <= 1'b1;
                mac_en  <= 1'b1;
                mac_upd <= 1'b1;
                mac_clr <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
          CLEAR: begin
            state    <= FEED;
            mac_clr  <= 1'b0;
            feed_cnt <= '0;
            row_vld  <= vld_nxt;
            col_vld  <= vld_nxt;
          end
          FEED: begin
            if (feed_cnt == t_last) begin
              state     <= DONE;
              mac_en    <= 1'b0;
              mac_upd   <= 1'b0;
              row_vld   <= '0;
              col_vld   <= '0;
              res_valid <= 1'b1;
            end else begin
              feed_cnt <= t_nxt;
              row_vld  <= vld_nxt;
              col_vld  <= vld_nxt;
            end
          end
          DONE: begin
            if (res_ack) begin
              state     <= IDLE;
              busy      <= 1'b0;
              feed_cnt  <= '0;
              res_valid <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule
